// File: rtl/sync_up_down_counter.sv
// sync_up_down_counter
//
// Synchronous up/down counter with parallel load, programmable modulus
// (count range 0..MAX), wrap or saturate behaviour at the bounds, a
// combinational terminal-count flag and a registered carry/borrow pulse.
// Every bit of Out changes on the same CLK edge, so downstream logic never
// sees ripple glitches.
//
// Parameters
//   WIDTH    counter width in bits (2..16)
//   MAX      top of the count range, 1..2**WIDTH-1
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   CLK   in   1      sole clock, rising edge
//   RST   in   1      asynchronous, active-high reset (clears Out and CO)
//   EN    in   1      count enable
//   UP    in   1      direction: 1 = increment, 0 = decrement
//   LOAD  in   1      synchronous parallel load, overrides EN
//   D     in   WIDTH  load value, clamped to MAX
//   Out   out  WIDTH  registered count
//   TC    out  1      terminal count: at MAX counting up, or at 0 counting down
//   CO    out  1      one-cycle pulse after each wrap edge
module sync_up_down_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = (2 ** WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Out,
  output logic             TC,
  output logic             CO
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  // Reject unsupported parameter combinations at elaboration time.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("sync_up_down_counter: WIDTH must be in 2..16");
  end
  if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("sync_up_down_counter: MAX must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             at_max, at_zero;

  assign at_max  = (out_q == MAX_V);
  assign at_zero = (out_q == '0);

  // Next-state logic. Priority: LOAD > EN > hold. The result never exceeds
  // MAX: loads are clamped and increments only happen below MAX.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    out_d = out_q;
    co_d  = 1'b0;
    if (LOAD) begin
      out_d = (D > MAX_V) ? MAX_V : D;
    end else if (EN) begin
      if (UP) begin
        if (!at_max) begin
          out_d = out_q + ONE_V;
        end else if (!SATURATE) begin
          out_d = '0;
          co_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          out_d = out_q - ONE_V;
        end else if (!SATURATE) begin
          out_d = MAX_V;
          co_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: non-blocking assignments for registered state, so every flop
    // samples the pre-edge value regardless of statement order.
    if (RST) begin
      out_q <= '0;
      co_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      co_q  <= co_d;
    end
  end

  assign Out = out_q;
  assign CO  = co_q;
  // TC follows UP combinationally, so a direction change is flagged at once.
  assign TC  = UP ? at_max : at_zero;

endmodule

// File: tb/tb_sync_up_down_counter.sv
module tb_sync_up_down_counter;

  localparam int N = 3;

  // Three configurations driven by the same inputs:
  //   0: defaults (MAX=15, wrap)  1: MAX=9, wrap  2: MAX=9, saturate
  int max_of [N] = '{15, 9, 9};
  bit sat_of [N] = '{1'b0, 1'b0, 1'b1};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0, UP = 1'b0, LOAD = 1'b0;
  logic [3:0] D = '0;

  logic [3:0] q_out [N];
  logic       q_tc  [N];
  logic       q_co  [N];

  sync_up_down_counter u_def (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .Out(q_out[0]), .TC(q_tc[0]), .CO(q_co[0]));

  sync_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_mod (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .Out(q_out[1]), .TC(q_tc[1]), .CO(q_co[1]));

  sync_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .Out(q_out[2]), .TC(q_tc[2]), .CO(q_co[2]));

  always #5 CLK = ~CLK;

  typedef struct {
    int out;
    int co;
    int tc;
  } exp_t;

  exp_t sb [N][$];
  int   m_out [N];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the count lives in 0..max; wrap mode is modular
  // arithmetic over max+1 values, saturate mode clips at the bounds.
  function automatic void model_next(input int i, input bit load, input int d,
                                     input bit en, input bit up,
                                     output int nout, output int nco);
    int mx = max_of[i];
    int o  = m_out[i];
    nout = o;
    nco  = 0;
    if (load) begin
      nout = (d > mx) ? mx : d;
    end else if (en) begin
      if (sat_of[i]) begin
        if (up) nout = (o < mx) ? o + 1 : o;
        else    nout = (o > 0)  ? o - 1 : o;
      end else begin
        nout = up ? (o + 1) % (mx + 1) : (o + mx) % (mx + 1);
        nco  = ((up && o == mx) || (!up && o == 0)) ? 1 : 0;
      end
    end
  endfunction

  function automatic int model_tc(input int i, input int o, input bit up);
    return (up ? (o == max_of[i]) : (o == 0)) ? 1 : 0;
  endfunction

  // Driver: inputs change on the falling edge; the expected post-edge state
  // is pushed into the scoreboard before the rising edge arrives.
  task automatic step(input bit load, input int d, input bit en, input bit up);
    int nout, nco;
    @(negedge CLK);
    RST  = 1'b0;
    LOAD = load;
    D    = 4'(d);
    EN   = en;
    UP   = up;
    #1;
    for (int i = 0; i < N; i++) begin
      // TC must already reflect the new UP with no clock edge.
      check($sformatf("tc_now[%0d]", i), q_tc[i], model_tc(i, m_out[i], up));
      model_next(i, load, d, en, up, nout, nco);
      m_out[i] = nout;
      sb[i].push_back('{out: nout, co: nco, tc: model_tc(i, nout, up)});
    end
  endtask

  // Assert reset between edges; Out and CO must clear with no edge and stay
  // clear across an edge. The following step() releases reset.
  task automatic reset_mid();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_out[%0d]", i), q_out[i], 0);
      check($sformatf("rst_co[%0d]", i), q_co[i], 0);
      m_out[i] = 0;
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_hold[%0d]", i), q_out[i], 0);
    end
  endtask

  // Monitor: every rising edge, compare each counter against the oldest
  // pending expectation (none are pending while reset is held).
  always begin
    exp_t e;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sb[i].size() > 0) begin
        e = sb[i].pop_front();
        check($sformatf("out[%0d]", i), q_out[i], e.out);
        check($sformatf("co[%0d]", i), q_co[i], e.co);
        check($sformatf("tc[%0d]", i), q_tc[i], e.tc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) m_out[i] = 0;

    // Power-on reset state.
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("por_out[%0d]", i), q_out[i], 0);
      check($sformatf("por_co[%0d]", i), q_co[i], 0);
      check($sformatf("por_tc[%0d]", i), q_tc[i], 1);
    end

    // Count to 7, reset between edges, then resume counting from 0.
    repeat (7) step(0, 0, 1, 1);
    reset_mid();
    step(0, 0, 1, 1);

    // Up wrap from 0 for 17 edges.
    step(1, 0, 0, 1);
    repeat (17) step(0, 0, 1, 1);

    // Reset while CO is high must clear it immediately.
    step(1, 15, 0, 1);
    step(0, 0, 1, 1);
    reset_mid();

    // Down wrap through the modulus.
    step(1, 2, 0, 0);
    repeat (5) step(0, 0, 1, 0);

    // Saturate at the top, then reverse.
    step(1, 8, 0, 1);
    repeat (4) step(0, 0, 1, 1);
    step(0, 0, 1, 0);

    // Load priority over a pending wrap, and clamping of D.
    step(1, 9, 0, 1);
    step(1, 13, 1, 1);
    step(1, 4, 1, 1);

    // Enable hold, then direction toggling every edge.
    step(1, 5, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);

    // Randomised traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(49) == 0) reset_mid();
      step(($urandom_range(7) == 0), int'($urandom_range(15)),
           ($urandom_range(3) != 0), bit'($urandom_range(1)));
    end

    // Drain: let the monitor consume the last expectation.
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      check($sformatf("sb_drain[%0d]", i), sb[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
